// File: rtl/cpu_multicycle.sv
// cpu_multicycle: multi-cycle RV32I/RV32E core with req/ack instruction and data buses.
// Each instruction walks FETCH -> EXEC -> (MEM) -> WB; any fault parks the core in HALT.
//
// Parameters:
//   RESET_PC    - PC loaded on reset
//   NUM_REGS    - 32 (RV32I) or 16 (RV32E); register indices >= NUM_REGS are illegal
//   BUS_TIMEOUT - cycles a request may wait for ack before halting, 0 = wait forever
//
// Ports:
//   i_clk, i_rst_n           - clock (rising edge), asynchronous active-low reset
//   o_ibus_req/addr          - instruction fetch request and address (= PC)
//   i_ibus_ack/rdata         - fetch completion and instruction word
//   o_dbus_req/we/addr       - data request, 1 = store, word-aligned address
//   o_dbus_wdata/strb        - store data replicated over lanes, byte enables (0 on loads)
//   i_dbus_ack/rdata         - data completion and full load word
//   o_pc                     - PC of the instruction in flight
//   o_retire                 - one-cycle pulse per retired instruction
//   o_halt                   - sticky halt on fault or EBREAK
//
// Optional feature macro CPU_PERF_COUNTERS_EN adds o_cycles[63:0] and o_instret[63:0].

module cpu_multicycle #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          NUM_REGS    = 32,
    parameter int          BUS_TIMEOUT = 0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_ibus_req,
    output logic [31:0] o_ibus_addr,
    input  logic        i_ibus_ack,
    input  logic [31:0] i_ibus_rdata,
    output logic        o_dbus_req,
    output logic        o_dbus_we,
    output logic [31:0] o_dbus_addr,
    output logic [31:0] o_dbus_wdata,
    output logic [3:0]  o_dbus_strb,
    input  logic        i_dbus_ack,
    input  logic [31:0] i_dbus_rdata,
    output logic [31:0] o_pc,
`ifdef CPU_PERF_COUNTERS_EN
    output logic [63:0] o_cycles,
    output logic [63:0] o_instret,
`endif
    output logic        o_retire,
    output logic        o_halt
);

    localparam logic [2:0] S_FETCH = 3'd0;
    localparam logic [2:0] S_EXEC  = 3'd1;
    localparam logic [2:0] S_MEM   = 3'd2;
    localparam logic [2:0] S_WB    = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    localparam int         RW   = $clog2(NUM_REGS);
    localparam logic [5:0] NREG = 6'(NUM_REGS);

    logic [2:0]  state;
    logic        run;
    logic [31:0] pc, instr;
    logic [31:0] regs [NUM_REGS];
    logic [31:0] wb_data, next_pc_r;
    logic [4:0]  wb_rd;
    logic        wb_en;
    logic [31:0] dbus_addr, dbus_wdata;
    logic [3:0]  dbus_strb;
    logic        dbus_we;
    logic [2:0]  ld_f3;
    logic [1:0]  ld_lane;
    logic [31:0] to_cnt;

    logic [6:0]  opcode, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, rs1_val, rs2_val;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign f3     = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign f7     = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'h000};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Out-of-range indices read as zero; EXEC faults on them anyway, this only keeps the read in bounds.
    assign rs1_val = ({1'b0, rs1} < NREG) ? regs[rs1[RW-1:0]] : 32'h0;
    assign rs2_val = ({1'b0, rs2} < NREG) ? regs[rs2[RW-1:0]] : 32'h0;

    function automatic logic [31:0] alu(input logic [2:0] f, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        case (f)
            3'b000:  alu = alt ? (a - b) : (a + b);
            3'b001:  alu = a << b[4:0];
            3'b010:  alu = {31'd0, $signed(a) < $signed(b)};
            3'b011:  alu = {31'd0, a < b};
            3'b100:  alu = a ^ b;
            3'b101: begin
                // Kept as separate branches so the arithmetic shift is not forced unsigned.
                if (alt) alu = $unsigned($signed(a) >>> b[4:0]);
                else     alu = a >> b[4:0];
            end
            3'b110:  alu = a | b;
            default: alu = a & b;
        endcase
    endfunction

    logic        ex_fault, ex_mem, ex_store, ex_wb_en, ex_use1, ex_use2, taken;
    logic [31:0] ex_result, ex_next_pc, ex_addr, ex_wdata;
    logic [3:0]  ex_strb;

    always_comb begin
        ex_fault   = 1'b0;
        ex_mem     = 1'b0;
        ex_store   = 1'b0;
        ex_wb_en   = 1'b0;
        ex_use1    = 1'b0;
        ex_use2    = 1'b0;
        taken      = 1'b0;
        ex_result  = 32'h0;
        ex_next_pc = pc + 32'd4;
        ex_addr    = rs1_val + imm_i;
        ex_wdata   = rs2_val;
        ex_strb    = 4'b0000;
        case (opcode)
            OP_LUI:   begin ex_wb_en = 1'b1; ex_result = imm_u; end
            OP_AUIPC: begin ex_wb_en = 1'b1; ex_result = pc + imm_u; end
            OP_JAL: begin
                ex_wb_en   = 1'b1;
                ex_result  = pc + 32'd4;
                ex_next_pc = pc + imm_j;
            end
            OP_JALR: begin
                ex_use1    = 1'b1;
                ex_wb_en   = 1'b1;
                ex_result  = pc + 32'd4;
                ex_next_pc = (rs1_val + imm_i) & ~32'd1;
                if (f3 != 3'b000) ex_fault = 1'b1;
            end
            OP_BRANCH: begin
                ex_use1 = 1'b1;
                ex_use2 = 1'b1;
                case (f3)
                    3'b000:  taken = (rs1_val == rs2_val);
                    3'b001:  taken = (rs1_val != rs2_val);
                    3'b100:  taken = ($signed(rs1_val) <  $signed(rs2_val));
                    3'b101:  taken = ($signed(rs1_val) >= $signed(rs2_val));
                    3'b110:  taken = (rs1_val <  rs2_val);
                    3'b111:  taken = (rs1_val >= rs2_val);
                    default: ex_fault = 1'b1;
                endcase
                if (taken) ex_next_pc = pc + imm_b;
            end
            OP_LOAD: begin
                ex_use1  = 1'b1;
                ex_mem   = 1'b1;
                ex_wb_en = 1'b1;
                case (f3)
                    3'b000, 3'b100: ;
                    3'b001, 3'b101: ex_fault = ex_addr[0];
                    3'b010:         ex_fault = (ex_addr[1:0] != 2'b00);
                    default:        ex_fault = 1'b1;
                endcase
            end
            OP_STORE: begin
                ex_use1  = 1'b1;
                ex_use2  = 1'b1;
                ex_mem   = 1'b1;
                ex_store = 1'b1;
                ex_addr  = rs1_val + imm_s;
                case (f3)
                    3'b000: begin
                        ex_strb  = 4'b0001 << ex_addr[1:0];
                        ex_wdata = {4{rs2_val[7:0]}};
                    end
                    3'b001: begin
                        ex_strb  = ex_addr[1] ? 4'b1100 : 4'b0011;
                        ex_wdata = {2{rs2_val[15:0]}};
                        ex_fault = ex_addr[0];
                    end
                    3'b010: begin
                        ex_strb  = 4'b1111;
                        ex_fault = (ex_addr[1:0] != 2'b00);
                    end
                    default: ex_fault = 1'b1;
                endcase
            end
            OP_IMM: begin
                ex_use1   = 1'b1;
                ex_wb_en  = 1'b1;
                ex_result = alu(f3, (f3 == 3'b101) & f7[5], rs1_val, imm_i);
                if (f3 == 3'b001 && f7 != 7'b0000000) ex_fault = 1'b1;
                if (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000) ex_fault = 1'b1;
            end
            OP_REG: begin
                ex_use1   = 1'b1;
                ex_use2   = 1'b1;
                ex_wb_en  = 1'b1;
                ex_result = alu(f3, f7[5], rs1_val, rs2_val);
                if (!(f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))))
                    ex_fault = 1'b1;
            end
            OP_FENCE: ;
            // SYSTEM (ECALL/EBREAK) and every unknown opcode stop the core.
            default: ex_fault = 1'b1;
        endcase
        // PC is always word aligned, so bit1 of next_pc only rises for a bad jump/branch target.
        if (ex_next_pc[1]) ex_fault = 1'b1;
        if (ex_use1 && {1'b0, rs1} >= NREG) ex_fault = 1'b1;
        if (ex_use2 && {1'b0, rs2} >= NREG) ex_fault = 1'b1;
        if (ex_wb_en && {1'b0, rd} >= NREG) ex_fault = 1'b1;
    end

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;

    always_comb begin
        case (ld_lane)
            2'd0:    ld_byte = i_dbus_rdata[7:0];
            2'd1:    ld_byte = i_dbus_rdata[15:8];
            2'd2:    ld_byte = i_dbus_rdata[23:16];
            default: ld_byte = i_dbus_rdata[31:24];
        endcase
        ld_half = ld_lane[1] ? i_dbus_rdata[31:16] : i_dbus_rdata[15:0];
        case (ld_f3)
            3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_val = {24'd0, ld_byte};
            3'b101:  ld_val = {16'd0, ld_half};
            default: ld_val = i_dbus_rdata;
        endcase
    end

    // A cycle counts towards the timeout only while a request is outstanding and unacknowledged.
    logic bus_wait, to_hit;
    assign bus_wait = (state == S_FETCH && run && !i_ibus_ack) || (state == S_MEM && !i_dbus_ack);
    assign to_hit   = (BUS_TIMEOUT > 0) && (to_cnt == 32'(BUS_TIMEOUT - 1));

    // run holds off the first fetch request until the first edge after reset release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_FETCH;
            run        <= 1'b0;
            pc         <= RESET_PC;
            instr      <= 32'h0;
            wb_data    <= 32'h0;
            next_pc_r  <= RESET_PC;
            wb_rd      <= 5'd0;
            wb_en      <= 1'b0;
            dbus_addr  <= 32'h0;
            dbus_wdata <= 32'h0;
            dbus_strb  <= 4'b0000;
            dbus_we    <= 1'b0;
            ld_f3      <= 3'b000;
            ld_lane    <= 2'b00;
            to_cnt     <= 32'h0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 32'h0;
        end else begin
            run    <= 1'b1;
            to_cnt <= bus_wait ? to_cnt + 32'd1 : 32'h0;
            case (state)
                S_FETCH: begin
                    if (run) begin
                        if (i_ibus_ack) begin
                            instr <= i_ibus_rdata;
                            state <= S_EXEC;
                        end else if (to_hit) begin
                            state <= S_HALT;
                        end
                    end
                end
                S_EXEC: begin
                    next_pc_r <= ex_next_pc;
                    wb_rd     <= rd;
                    wb_en     <= ex_wb_en;
                    wb_data   <= ex_result;
                    dbus_addr <= {ex_addr[31:2], 2'b00};
                    dbus_we   <= ex_store;
                    dbus_wdata<= ex_wdata;
                    dbus_strb <= ex_strb;
                    ld_f3     <= f3;
                    ld_lane   <= ex_addr[1:0];
                    if (ex_fault)    state <= S_HALT;
                    else if (ex_mem) state <= S_MEM;
                    else             state <= S_WB;
                end
                S_MEM: begin
                    if (i_dbus_ack) begin
                        if (!dbus_we) wb_data <= ld_val;
                        state <= S_WB;
                    end else if (to_hit) begin
                        state <= S_HALT;
                    end
                end
                S_WB: begin
                    if (wb_en && wb_rd != 5'd0) regs[wb_rd[RW-1:0]] <= wb_data;
                    pc    <= next_pc_r;
                    state <= S_FETCH;
                end
                default: state <= S_HALT;
            endcase
        end
    end

`ifdef CPU_PERF_COUNTERS_EN
    logic [63:0] cycles, instret;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cycles  <= 64'd0;
            instret <= 64'd0;
        end else begin
            cycles <= cycles + 64'd1;
            if (state == S_WB) instret <= instret + 64'd1;
        end
    end

    assign o_cycles  = cycles;
    assign o_instret = instret;
`endif

    assign o_ibus_req   = (state == S_FETCH) && run;
    assign o_ibus_addr  = pc;
    assign o_dbus_req   = (state == S_MEM);
    assign o_dbus_we    = dbus_we;
    assign o_dbus_addr  = dbus_addr;
    assign o_dbus_wdata = dbus_wdata;
    assign o_dbus_strb  = dbus_strb;
    assign o_pc         = pc;
    assign o_retire     = (state == S_WB);
    assign o_halt       = (state == S_HALT);

endmodule

// File: tb/tb_cpu_multicycle.sv
// tb_cpu_multicycle: scoreboard bench for cpu_multicycle (RESET_PC=0x100, RV32E, BUS_TIMEOUT=8).
// Directed programs are loaded into a behavioural instruction memory; expected retires and
// data-bus transactions are queued up front and a negedge monitor pops and compares them.

module tb_cpu_multicycle;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        o_ibus_req, o_dbus_req, o_dbus_we, o_retire, o_halt;
    logic [31:0] o_ibus_addr, o_dbus_addr, o_dbus_wdata, o_pc;
    logic [3:0]  o_dbus_strb;
    logic        i_ibus_ack = 1'b0, i_dbus_ack = 1'b0;
    logic [31:0] i_ibus_rdata = 32'h0, i_dbus_rdata = 32'h0;
`ifdef CPU_PERF_COUNTERS_EN
    logic [63:0] o_cycles, o_instret;
`endif

    always #5 i_clk = ~i_clk;

    cpu_multicycle #(.RESET_PC(32'h100), .NUM_REGS(16), .BUS_TIMEOUT(8)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .o_ibus_req(o_ibus_req), .o_ibus_addr(o_ibus_addr),
        .i_ibus_ack(i_ibus_ack), .i_ibus_rdata(i_ibus_rdata),
        .o_dbus_req(o_dbus_req), .o_dbus_we(o_dbus_we), .o_dbus_addr(o_dbus_addr),
        .o_dbus_wdata(o_dbus_wdata), .o_dbus_strb(o_dbus_strb),
        .i_dbus_ack(i_dbus_ack), .i_dbus_rdata(i_dbus_rdata),
        .o_pc(o_pc),
`ifdef CPU_PERF_COUNTERS_EN
        .o_cycles(o_cycles), .o_instret(o_instret),
`endif
        .o_retire(o_retire), .o_halt(o_halt)
    );

    typedef struct {
        logic        is_ret;
        logic [31:0] pc;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } ev_t;

    ev_t         exp_q[$];
    logic [31:0] imem [logic [31:0]];
    logic [31:0] dmem [logic [31:0]];
    int          i_wait = 0;
    int          i_cnt = 0;
    bit          d_noack = 1'b0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic        prev_dreq = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rd, op};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    task automatic expRetire(input logic [31:0] pc);
        ev_t e;
        e = '{is_ret: 1'b1, pc: pc, we: 1'b0, addr: 32'h0, strb: 4'h0, wdata: 32'h0};
        exp_q.push_back(e);
    endtask

    task automatic expDbus(input logic we, input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wdata);
        ev_t e;
        e = '{is_ret: 1'b0, pc: 32'h0, we: we, addr: addr, strb: strb, wdata: wdata};
        exp_q.push_back(e);
    endtask

    // Instruction memory responder: acks after i_wait wait cycles, zero means same-cycle ack.
    always @(negedge i_clk) begin
        if (o_ibus_req) begin
            if (i_cnt >= i_wait) begin
                i_ibus_ack   = 1'b1;
                i_ibus_rdata = imem.exists(o_ibus_addr) ? imem[o_ibus_addr] : 32'h0;
                i_cnt        = 0;
            end else begin
                i_ibus_ack = 1'b0;
                i_cnt++;
            end
        end else begin
            i_ibus_ack = 1'b0;
            i_cnt      = 0;
        end
    end

    // Data memory responder: zero-wait unless d_noack stalls it forever.
    always @(negedge i_clk) begin
        if (o_dbus_req && !d_noack) begin
            i_dbus_ack   = 1'b1;
            i_dbus_rdata = dmem.exists(o_dbus_addr) ? dmem[o_dbus_addr] : 32'h0;
        end else begin
            i_dbus_ack = 1'b0;
        end
    end

    always @(posedge i_clk) begin
        if (!i_rst_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    // Monitor: every retire pulse and every new data request must match the head of the queue.
    always @(negedge i_clk) begin
        ev_t e;
        if (i_rst_n) begin
            if (o_dbus_req && !prev_dreq) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("[TB] FAIL unexpected_dbus: got addr %h, expected no request", o_dbus_addr);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("event_order_dbus", 32'(o_retire), 32'(e.is_ret));
                    checkOutput("dbus_we", 32'(o_dbus_we), 32'(e.we));
                    checkOutput("dbus_addr", o_dbus_addr, e.addr);
                    checkOutput("dbus_strb", 32'(o_dbus_strb), 32'(e.strb));
                    if (e.we) checkOutput("dbus_wdata", o_dbus_wdata, e.wdata);
                end
            end
            if (o_retire) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("[TB] FAIL unexpected_retire: got pc %h, expected no retire", o_pc);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("event_order_retire", 32'(o_retire), 32'(e.is_ret));
                    checkOutput("retire_pc", o_pc, e.pc);
                end
            end
        end
        prev_dreq = o_dbus_req;
    end

    // Loads a phase's program and expectations, then releases reset at a falling edge.
    task automatic applyStimulus(input int phase);
        i_rst_n = 1'b0;
        exp_q.delete();
        imem.delete();
        dmem.delete();
        i_wait  = 0;
        d_noack = 1'b0;
        case (phase)
            0: begin
                imem[32'h100] = enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011);
                imem[32'h104] = enc_s(12'h300, 5'd1, 5'd0, 3'b010);
                imem[32'h108] = enc_u(20'hAABBD, 5'd2, 7'b0110111);
                imem[32'h10C] = enc_i(12'hCDD, 5'd2, 3'b000, 5'd2, 7'b0010011);
                imem[32'h110] = enc_s(12'h203, 5'd2, 5'd0, 3'b000);
                imem[32'h114] = enc_i(12'h203, 5'd0, 3'b000, 5'd3, 7'b0000011);
                imem[32'h118] = enc_s(12'h304, 5'd3, 5'd0, 3'b010);
                imem[32'h11C] = enc_i(12'h203, 5'd0, 3'b100, 5'd4, 7'b0000011);
                imem[32'h120] = enc_s(12'h308, 5'd4, 5'd0, 3'b010);
                imem[32'h124] = enc_j(21'h1FFF1C, 5'd0);
                imem[32'h040] = enc_b(13'h1FF8, 5'd0, 5'd0, 3'b000);
                imem[32'h038] = enc_u(20'h00001, 5'd2, 7'b0110111);
                imem[32'h03C] = enc_i(12'd3, 5'd2, 3'b000, 5'd1, 7'b1100111);
                dmem[32'h200] = 32'h8000_0000;
                expRetire(32'h100);
                expDbus(1'b1, 32'h300, 4'b1111, 32'h0000_0005);  expRetire(32'h104);
                expRetire(32'h108);
                expRetire(32'h10C);
                expDbus(1'b1, 32'h200, 4'b1000, 32'hDDDD_DDDD);  expRetire(32'h110);
                expDbus(1'b0, 32'h200, 4'b0000, 32'h0);          expRetire(32'h114);
                expDbus(1'b1, 32'h304, 4'b1111, 32'hFFFF_FF80);  expRetire(32'h118);
                expDbus(1'b0, 32'h200, 4'b0000, 32'h0);          expRetire(32'h11C);
                expDbus(1'b1, 32'h308, 4'b1111, 32'h0000_0080);  expRetire(32'h120);
                expRetire(32'h124);
                expRetire(32'h040);
                expRetire(32'h038);
            end
            1: begin
                i_wait = 4;
                imem[32'h100] = enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011);
                expRetire(32'h100);
            end
            2: begin
                imem[32'h100] = enc_i(12'd1, 5'd0, 3'b000, 5'd15, 7'b0010011);
                imem[32'h104] = enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd17);
                expRetire(32'h100);
            end
            default: begin
                d_noack = 1'b1;
                imem[32'h100] = enc_i(12'd0, 5'd0, 3'b010, 5'd1, 7'b0000011);
                expDbus(1'b0, 32'h000, 4'b0000, 32'h0);
            end
        endcase
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic waitHalt(input int budget);
        for (int i = 0; i < budget && !o_halt; i++) @(negedge i_clk);
        checkOutput("halt_reached", 32'(o_halt), 32'd1);
    endtask

    task automatic waitRetire(input int budget);
        for (int i = 0; i < budget && !o_retire; i++) @(negedge i_clk);
        checkOutput("retire_seen", 32'(o_retire), 32'd1);
    endtask

    initial begin
        int dreq_cycles;

        // Zero-wait program: reset state, ALU, byte stores/loads, JAL, BEQ back, bad JALR target.
        applyStimulus(0);
        checkOutput("rst_ibus_req", 32'(o_ibus_req), 32'd0);
        checkOutput("rst_dbus_req", 32'(o_dbus_req), 32'd0);
        checkOutput("rst_retire", 32'(o_retire), 32'd0);
        checkOutput("rst_halt", 32'(o_halt), 32'd0);
        checkOutput("rst_pc", o_pc, 32'h100);
        @(negedge i_clk);
        checkOutput("first_fetch_req", 32'(o_ibus_req), 32'd1);
        checkOutput("first_fetch_addr", o_ibus_addr, 32'h100);
        waitRetire(20);
        checkOutput("addi_retire_cycle", 32'(cyc), 32'd3);
        waitHalt(200);
        checkOutput("jalr_halt_pc", o_pc, 32'h3C);
        checkOutput("halt_ibus_req", 32'(o_ibus_req), 32'd0);
        checkOutput("halt_dbus_req", 32'(o_dbus_req), 32'd0);
        checkOutput("jalr_x1_kept", dut.regs[1], 32'd5);
        repeat (3) @(negedge i_clk);
        checkOutput("halt_sticky", 32'(o_halt), 32'd1);
        checkOutput("halt_pc_frozen", o_pc, 32'h3C);
        checkOutput("phase0_drained", 32'(exp_q.size()), 32'd0);

        // Fetch ack delayed by four cycles: address must hold and retire slips by four.
        applyStimulus(1);
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            checkOutput("wait_fetch_req", 32'(o_ibus_req), 32'd1);
            checkOutput("wait_fetch_addr", o_ibus_addr, 32'h100);
        end
        waitRetire(20);
        checkOutput("delayed_retire_cycle", 32'(cyc), 32'd7);
        waitHalt(40);
        checkOutput("phase1_drained", 32'(exp_q.size()), 32'd0);

        // RV32E: x15 is the last legal register, x17 must halt without retiring.
        applyStimulus(2);
        waitHalt(40);
        checkOutput("rv32e_halt_pc", o_pc, 32'h104);
        checkOutput("rv32e_x15", dut.regs[15], 32'd1);
        checkOutput("phase2_drained", 32'(exp_q.size()), 32'd0);

        // Data bus never acks: halt after eight request cycles, then async reset out of HALT.
        applyStimulus(3);
        dreq_cycles = 0;
        for (int i = 0; i < 60 && !o_halt; i++) begin
            @(negedge i_clk);
            if (o_dbus_req) dreq_cycles++;
        end
        checkOutput("timeout_halt", 32'(o_halt), 32'd1);
        checkOutput("timeout_req_cycles", 32'(dreq_cycles), 32'd8);
        checkOutput("timeout_dbus_dropped", 32'(o_dbus_req), 32'd0);
        checkOutput("phase3_drained", 32'(exp_q.size()), 32'd0);
        #2;
        i_rst_n = 1'b0;
        #1;
        checkOutput("async_rst_halt", 32'(o_halt), 32'd0);
        checkOutput("async_rst_ibus_req", 32'(o_ibus_req), 32'd0);
        checkOutput("async_rst_dbus_req", 32'(o_dbus_req), 32'd0);
        checkOutput("async_rst_pc", o_pc, 32'h100);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
